// File: rtl/alu_issue_stage.sv
// Decode/issue slot for RV32I: turns one instruction plus its register read data into an
// ALU operand/operation bundle and holds it in a single valid/ready output register.
module alu_issue_stage #(
  parameter int XLEN           = 32,
  parameter int ALU_CTRL_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [XLEN-1:0]           in_rs1_data,
  input  logic [XLEN-1:0]           in_rs2_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           Operand1,
  output logic [XLEN-1:0]           Operand2,
  output logic [ALU_CTRL_WIDTH-1:0] Operation,
  output logic [4:0]                out_rd,
  output logic                      out_reg_we,
  output logic                      out_mem_re,
  output logic                      out_mem_we,
  output logic [2:0]                out_funct3,
  output logic [XLEN-1:0]           out_store_data,
  output logic                      out_is_branch,
  output logic                      out_is_jump,
  output logic [XLEN-1:0]           out_pc,
  output logic                      out_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_rd;

  assign w_opcode = in_instr[6:0];
  assign w_funct3 = in_instr[14:12];
  assign w_funct7 = in_instr[31:25];
  assign w_rd     = in_instr[11:7];

  // Immediates built at 32 bits as signed values so the resize sign-extends to XLEN.
  logic signed [31:0] w_imm_i32, w_imm_s32, w_imm_u32, w_imm_j32;
  logic [XLEN-1:0]    w_imm_i, w_imm_s, w_imm_u, w_imm_j, w_shamt;

  assign w_imm_i32 = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_u32 = {in_instr[31:12], 12'b0};
  assign w_imm_j32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign w_imm_i   = XLEN'(w_imm_i32);
  assign w_imm_s   = XLEN'(w_imm_s32);
  assign w_imm_u   = XLEN'(w_imm_u32);
  assign w_imm_j   = XLEN'(w_imm_j32);
  assign w_shamt   = XLEN'(in_instr[24:20]);

  logic [4:0]      w_op;
  logic [XLEN-1:0] w_opnd1, w_opnd2;
  logic            w_rd_used, w_mem_re, w_mem_we, w_branch, w_jump, w_illegal;

  always_comb begin
    w_op      = 5'b00000;
    w_opnd1   = in_rs1_data;
    w_opnd2   = in_rs2_data;
    w_rd_used = 1'b0;
    w_mem_re  = 1'b0;
    w_mem_we  = 1'b0;
    w_branch  = 1'b0;
    w_jump    = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_rd_used = 1'b1;
        w_op      = {1'b0, w_funct7[5], w_funct3};
        w_illegal = !((w_funct7 == 7'h00) ||
                      (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101)));
      end
      OP_IMM: begin
        w_rd_used = 1'b1;
        if (w_funct3 == 3'b001) begin
          w_op      = 5'b00001;
          w_opnd2   = w_shamt;
          w_illegal = (w_funct7 != 7'h00);
        end else if (w_funct3 == 3'b101) begin
          w_op      = {1'b0, w_funct7[5], 3'b101};
          w_opnd2   = w_shamt;
          w_illegal = !(w_funct7 == 7'h00 || w_funct7 == 7'h20);
        end else begin
          w_op    = {2'b00, w_funct3};
          w_opnd2 = w_imm_i;
        end
      end
      OP_LOAD: begin
        w_rd_used = 1'b1;
        w_mem_re  = 1'b1;
        w_opnd2   = w_imm_i;
        w_illegal = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        w_mem_we  = 1'b1;
        w_opnd2   = w_imm_s;
        w_illegal = (w_funct3 > 3'b010);
      end
      OP_AUIPC: begin
        w_rd_used = 1'b1;
        w_opnd1   = in_pc;
        w_opnd2   = w_imm_u;
      end
      OP_JAL: begin
        w_rd_used = 1'b1;
        w_jump    = 1'b1;
        w_opnd1   = in_pc;
        w_opnd2   = w_imm_j;
      end
      OP_JALR: begin
        w_rd_used = 1'b1;
        w_jump    = 1'b1;
        w_op      = 5'b11001;
        w_opnd2   = w_imm_i;
        w_illegal = (w_funct3 != 3'b000);
      end
      OP_LUI: begin
        w_rd_used = 1'b1;
        w_op      = 5'b11000;
        w_opnd1   = '0;
        w_opnd2   = w_imm_u;
      end
      OP_BRANCH: begin
        // Target arithmetic lives downstream; the ALU only compares rs1 against rs2.
        w_branch  = 1'b1;
        w_op      = {2'b10, w_funct3};
        w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_op      = 5'b00000;
      w_rd_used = 1'b0;
      w_mem_re  = 1'b0;
      w_mem_we  = 1'b0;
      w_branch  = 1'b0;
      w_jump    = 1'b0;
    end
  end

  logic w_load;
  assign in_ready = !out_valid || out_ready;
  assign w_load   = in_valid && in_ready && !flush;

  logic                      r_valid;
  logic [XLEN-1:0]           r_opnd1, r_opnd2, r_store_data, r_pc;
  logic [ALU_CTRL_WIDTH-1:0] r_op;
  logic [4:0]                r_rd;
  logic [2:0]                r_funct3;
  logic                      r_reg_we, r_mem_re, r_mem_we, r_branch, r_jump, r_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_opnd1      <= '0;
      r_opnd2      <= '0;
      r_store_data <= '0;
      r_pc         <= '0;
      r_op         <= '0;
      r_rd         <= '0;
      r_funct3     <= '0;
      r_reg_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid      <= 1'b1;
      r_opnd1      <= w_opnd1;
      r_opnd2      <= w_opnd2;
      r_store_data <= w_mem_we ? in_rs2_data : '0;
      r_pc         <= in_pc;
      r_op         <= ALU_CTRL_WIDTH'(w_op);
      r_rd         <= w_rd_used ? w_rd : 5'd0;
      r_funct3     <= w_funct3;
      r_reg_we     <= w_rd_used && (w_rd != 5'd0);
      r_mem_re     <= w_mem_re;
      r_mem_we     <= w_mem_we;
      r_branch     <= w_branch;
      r_jump       <= w_jump;
      r_illegal    <= w_illegal;
    end else if (out_ready) begin
      // Consumed with nothing new: drop valid, leave the payload as it was.
      r_valid <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign Operand1       = r_opnd1;
  assign Operand2       = r_opnd2;
  assign Operation      = r_op;
  assign out_rd         = r_rd;
  assign out_reg_we     = r_reg_we;
  assign out_mem_re     = r_mem_re;
  assign out_mem_we     = r_mem_we;
  assign out_funct3     = r_funct3;
  assign out_store_data = r_store_data;
  assign out_is_branch  = r_branch;
  assign out_is_jump    = r_jump;
  assign out_pc         = r_pc;
  assign out_illegal    = r_illegal;

endmodule
